stream_accumulator: RTL
=======================

Name: stream_accumulator

Overview:
- Parametrised successor to the team's single-channel go/terminate summer.
- After a start strobe, accumulates a stream of unsigned words over a valid/ready handshake until a zero-valued word arrives, then reports the sum, the term count and the overflow status.
- Adds over the earlier summer:
  - independent data and sum widths;
  - backpressure (`in_ready`);
  - a term counter;
  - a sticky overflow flag;
  - optional saturation.
- Sits between a producer FIFO and a result register bank.

Parameters:
- `DATA_W`, 16: width of input words.
- `SUM_W`, 24: width of the accumulator and `sum` output. Must be ≥ `DATA_W`.
- `CNT_W`, 8: width of the term counter.

Ports:
- `clk` input 1: single clock, all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `go_l` input 1: active-low start request, sampled in IDLE only.
- `in_valid` input 1: producer has a word on `in_data`.
- `in_data` input `DATA_W`: unsigned input word; value 0 terminates the stream.
- `in_ready` output 1: block accepts a word this cycle.
- `busy` output 1: high in ACCUM.
- `done` output 1: one-cycle pulse when a stream completes.
- `sum` output `SUM_W`: accumulated sum. Held stable from completion until the next start.
- `count` output `CNT_W`: number of non-zero terms accepted.
- `overflow` output 1: sticky; set if any addition carried out of `SUM_W` bits.

Behaviour:
- Reset (`rst`=1 at a clock edge, from any state, including mid-stream):
  - state goes to IDLE;
  - `sum`=0, `count`=0, `overflow`=0, `done`=0, `busy`=0, `in_ready`=0.
- States: IDLE, ACCUM, DONE.
- IDLE:
  - `in_ready`=0; `sum`, `count`, `overflow` hold their last values.
  - `go_l`=0 → ACCUM; on the same edge `sum`, `count` and `overflow` are cleared to 0.
- ACCUM:
  - `in_ready`=1, `busy`=1. A word is accepted when `in_valid` && `in_ready`.
  - Accepted non-zero word:
    - `sum` ← `sum` + zero-extended `in_data`;
    - `count` ← `count`+1, saturating at all-ones;
    - stay in ACCUM.
  - Accepted zero word → DONE. `sum`, `count` and `overflow` are unchanged; the zero is not counted.
  - `in_valid`=0: nothing changes.
  - `go_l` is ignored in ACCUM.
- DONE:
  - `done`=1 for exactly one cycle, `in_ready`=0, `busy`=0.
  - Unconditional → IDLE. `go_l` is ignored in DONE.
- Latency: zero word accepted at edge N → `done` high during cycle N to N+1. Earliest restart is one cycle after DONE, from IDLE.
- Arithmetic: the addition is computed at `SUM_W`+1 bits.
  - A carry out sets `overflow`, which stays set until the next start or reset.
  - Wrap versus clamp is governed by the Optional Feature.
- Count saturation: `count` stays at 2^`CNT_W`-1; accumulation continues unaffected.
- Empty stream (first accepted word is 0): DONE with `sum`=0, `count`=0, `overflow`=0.
- All outputs are registered, except `in_ready` and `busy`, which decode directly from the state register.

Optional Feature:
- Macro: `STREAM_ACCUMULATOR_SATURATE_EN`.
- Defined: on an addition carry out, `sum` clamps to all-ones (2^`SUM_W`-1) and stays there for the rest of the stream. `overflow` is set.
- Undefined: `sum` wraps modulo 2^`SUM_W`. `overflow` is still set.
- All other behaviour is identical.

Test Plan:
- Basic stream. Defaults; reset; `go_l` low for 1 cycle; feed 3, 5, 7, 0 with `in_valid` held high.
  → `done` pulses one cycle after the 0 is accepted, with `sum`=15, `count`=3, `overflow`=0. `sum` is then held at 15 in IDLE.
- Backpressure and gaps. Feed 10, idle for 2 cycles, then 20, 0.
  → `sum`=30, `count`=2.
  → `in_ready`=0 in IDLE and DONE. Words presented in IDLE are not accumulated.
- Overflow. `SUM_W`=16, `DATA_W`=16; feed 0xFFF0, 0x0020, 0.
  → macro undefined: `sum`=0x0010, `overflow`=1.
  → macro defined: `sum`=0xFFFF, `overflow`=1.
  → a following start clears `overflow` to 0.
- Empty stream and count saturation.
  → Start then 0: `done` with `sum`=0, `count`=0.
  → `CNT_W`=2; feed five 1s then 0: `count`=3, `sum`=5.
- Reset mid-stream. Feed 4, 4, then assert `rst` for 1 cycle.
  → All outputs are 0 and the state is IDLE.
  → A subsequent start with 9, 0 gives `sum`=9, `count`=1.
- Ignored start. Hold `go_l`=0 continuously through a stream of 2, 0.
  → `sum`=2. `go_l` has no effect in ACCUM and DONE.
  → A new stream starts on the first IDLE cycle after DONE and clears `sum`.

Source files
------------

// File: rtl/stream_accumulator.sv
// stream_accumulator
//
// Purpose:
//   Accumulates a stream of unsigned words over a valid/ready handshake.
//   Accumulation starts on an active-low start request and ends when a zero
//   word arrives. The block then reports the sum, the number of non-zero
//   terms and whether any addition carried out of the accumulator.
//   It sits between a producer FIFO and a result register bank.
//
// Configuration:
//   STREAM_ACCUMULATOR_SATURATE_EN
//     defined   : on a carry out, sum clamps to all-ones for the rest of the stream
//     undefined : sum wraps modulo 2^SUM_W
//     In both cases overflow is set on a carry out.
//
// Parameters:
//   DATA_W : width of input words
//   SUM_W  : width of the accumulator and sum output (must be >= DATA_W)
//   CNT_W  : width of the term counter
//
// Ports:
//   clk      in   single clock, rising edge
//   rst      in   synchronous active-high reset
//   go_l     in   active-low start request, honoured in IDLE only
//   in_valid in   producer has a word on in_data
//   in_data  in   unsigned word; zero terminates the stream
//   in_ready out  word accepted this cycle when in_valid is also high
//   busy     out  high while accumulating
//   done     out  one-cycle pulse when a stream completes
//   sum      out  accumulated sum, held from completion until the next start
//   count    out  number of non-zero terms accepted, saturating
//   overflow out  sticky carry-out flag, cleared at start
//
// State | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for go_l low; results held
// ACCUM | accepting words; non-zero words add into sum and count
// DONE  | zero word seen; done pulses for this one cycle

module stream_accumulator #(
    parameter int DATA_W = 16,
    parameter int SUM_W  = 24,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go_l,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              busy,
    output logic              done,
    output logic [SUM_W-1:0]  sum,
    output logic [CNT_W-1:0]  count,
    output logic              overflow
);

    localparam int PAD = SUM_W + 1 - DATA_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [SUM_W-1:0] SUM_MAX = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state;

    // One extra bit so the carry out of the accumulator is visible.
    logic [SUM_W:0]   add_full;
    logic [SUM_W-1:0] sum_next;
    logic             accept;

    assign add_full = {1'b0, sum} + {{PAD{1'b0}}, in_data};

`ifdef STREAM_ACCUMULATOR_SATURATE_EN
    // Once clamped, every later non-zero add carries again, so the clamp
    // holds for the remainder of the stream without extra state.
    assign sum_next = add_full[SUM_W] ? SUM_MAX : add_full[SUM_W-1:0];
`else
    assign sum_next = add_full[SUM_W-1:0];
`endif

    assign in_ready = (state == ACCUM);
    assign busy     = (state == ACCUM);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sum      <= '0;
            count    <= '0;
            overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (!go_l) begin
                        state    <= ACCUM;
                        sum      <= '0;
                        count    <= '0;
                        overflow <= 1'b0;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        if (in_data == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            sum      <= sum_next;
                            overflow <= overflow | add_full[SUM_W];
                            if (count != CNT_MAX) begin
                                count <= count + 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
